// File: rtl/gp_regfile.sv
// General-purpose register file with one write port, two combinational read ports and a
// per-register busy scoreboard. Define GP_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module gp_regfile #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned ZERO_R0  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [DATA_W-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                rsv_err
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                rsv_err_q;

    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] rsv_dec;
    logic [NUM_REGS-1:0] rd_dec_a;
    logic [NUM_REGS-1:0] rd_dec_b;

    // An address is usable when it is in range and is not the hardwired zero register.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        addr_valid = (32'(addr) < NUM_REGS) && !((ZERO_R0 != 0) && (addr == '0));
    endfunction

    // One-hot decodes; invalid addresses decode to all zeros.
    always_comb begin
        wr_dec   = '0;
        rsv_dec  = '0;
        rd_dec_a = '0;
        rd_dec_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_dec[i]   = wr_en  && addr_valid(wr_addr)   && (wr_addr   == ADDR_W'(i));
            rsv_dec[i]  = rsv_en && addr_valid(rsv_addr)  && (rsv_addr  == ADDR_W'(i));
            rd_dec_a[i] = addr_valid(rd_addr_a) && (rd_addr_a == ADDR_W'(i));
            rd_dec_b[i] = addr_valid(rd_addr_b) && (rd_addr_b == ADDR_W'(i));
        end
    end

    // Register storage: every register loads independently from the shared write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_dec[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard: a new reservation beats a same-cycle writeback clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (rsv_dec[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_dec[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
            rsv_err_q <= |(rsv_dec & busy_q);
        end
    end

    logic [DATA_W-1:0] reg_data_a;
    logic [DATA_W-1:0] reg_data_b;
    logic              reg_busy_a;
    logic              reg_busy_b;

    // Registered-state read muxes; unselected registers contribute zero.
    always_comb begin
        reg_data_a = '0;
        reg_data_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_dec_a[i]) begin
                reg_data_a = regs[i];
            end
            if (rd_dec_b[i]) begin
                reg_data_b = regs[i];
            end
        end
        reg_busy_a = |(rd_dec_a & busy_q);
        reg_busy_b = |(rd_dec_b & busy_q);
    end

`ifdef GP_REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;

    // Forward the in-flight writeback; a same-cycle reservation keeps the register busy.
    always_comb begin
        hit_a     = |(wr_dec & rd_dec_a);
        hit_b     = |(wr_dec & rd_dec_b);
        rd_data_a = reg_data_a;
        rd_data_b = reg_data_b;
        busy_a    = reg_busy_a;
        busy_b    = reg_busy_b;
        if (hit_a) begin
            rd_data_a = wr_data;
            busy_a    = |(rsv_dec & rd_dec_a);
        end
        if (hit_b) begin
            rd_data_b = wr_data;
            busy_b    = |(rsv_dec & rd_dec_b);
        end
    end
`else
    assign rd_data_a = reg_data_a;
    assign rd_data_b = reg_data_b;
    assign busy_a    = reg_busy_a;
    assign busy_b    = reg_busy_b;
`endif

    assign busy_vec = busy_q;
    assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_gp_regfile.sv
// Directed bench for gp_regfile: a default instance (4 regs) and a ZERO_R0 instance (3 regs)
// share the same stimulus.
module tb_gp_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic       rsv_en;
    logic [1:0] rsv_addr;

    logic [7:0] rd_data_a, rd_data_b;
    logic       busy_a, busy_b, rsv_err;
    logic [3:0] busy_vec;

    logic [7:0] z_rd_data_a, z_rd_data_b;
    logic       z_busy_a, z_busy_b, z_rsv_err;
    logic [2:0] z_busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gp_regfile #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_R0(0)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(busy_a), .busy_b(busy_b),
        .busy_vec(busy_vec), .rsv_err(rsv_err)
    );

    gp_regfile #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_data_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(z_busy_a), .busy_b(z_busy_b),
        .busy_vec(z_busy_vec), .rsv_err(z_rsv_err)
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [1:0] ra;
        logic [1:0] aa;
        logic [1:0] ab;
        logic [7:0] eda;
        logic [7:0] edb;
        logic       eba;
        logic       ebb;
        logic [3:0] ebv;
        logic       eerr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic we, input logic [1:0] wa,
                                input logic [7:0] wd, input logic re, input logic [1:0] ra,
                                input logic [1:0] aa, input logic [1:0] ab,
                                input logic [7:0] eda, input logic [7:0] edb,
                                input logic eba, input logic ebb,
                                input logic [3:0] ebv, input logic eerr);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.aa = aa; v.ab = ab; v.eda = eda; v.edb = edb; v.eba = eba; v.ebb = ebb;
        v.ebv = ebv; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic re, input logic [1:0] ra, input logic [1:0] aa, input logic [1:0] ab);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rd_addr_a = aa; rd_addr_b = ab;
    endtask

    initial begin
        // Each row: inputs for one cycle and outputs expected before that cycle's edge.
        vecs[0]  = mk(0,1,2,8'hA5,0,0,0,3, 8'h00,8'h00,0,0,4'b0000,0);
        vecs[1]  = mk(0,1,3,8'h3C,0,0,2,1, 8'hA5,8'h00,0,0,4'b0000,0);
        vecs[2]  = mk(0,0,0,8'h00,0,0,2,3, 8'hA5,8'h3C,0,0,4'b0000,0);
        vecs[3]  = mk(0,0,0,8'h00,0,0,0,1, 8'h00,8'h00,0,0,4'b0000,0);
        vecs[4]  = mk(0,0,0,8'h00,1,1,1,1, 8'h00,8'h00,0,0,4'b0000,0);
        vecs[5]  = mk(0,0,0,8'h00,0,0,1,2, 8'h00,8'hA5,1,0,4'b0010,0);
        vecs[6]  = mk(0,0,0,8'h00,1,1,1,1, 8'h00,8'h00,1,1,4'b0010,0);
        vecs[7]  = mk(0,0,0,8'h00,0,0,1,0, 8'h00,8'h00,1,0,4'b0010,1);
        vecs[8]  = mk(0,0,0,8'h00,0,0,1,3, 8'h00,8'h3C,1,0,4'b0010,0);
        vecs[9]  = mk(0,1,1,8'h77,0,0,3,2, 8'h3C,8'hA5,0,0,4'b0010,0);
        vecs[10] = mk(0,0,0,8'h00,0,0,1,1, 8'h77,8'h77,0,0,4'b0000,0);
        vecs[11] = mk(0,1,2,8'h11,1,2,0,3, 8'h00,8'h3C,0,0,4'b0000,0);
        vecs[12] = mk(0,0,0,8'h00,0,0,2,0, 8'h11,8'h00,1,0,4'b0100,0);
        vecs[13] = mk(0,1,2,8'h22,1,3,1,3, 8'h77,8'h3C,0,0,4'b0100,0);
        vecs[14] = mk(0,0,0,8'h00,0,0,2,3, 8'h22,8'h3C,0,1,4'b1000,0);
        vecs[15] = mk(0,1,1,8'h99,1,0,0,0, 8'h00,8'h00,0,0,4'b1000,0);
        vecs[16] = mk(0,0,0,8'h00,0,0,0,1, 8'h00,8'h99,1,0,4'b1001,0);
        vecs[17] = mk(1,1,3,8'hFF,1,1,2,1, 8'h22,8'h99,0,0,4'b1001,0);
        vecs[18] = mk(0,0,0,8'h00,0,0,3,1, 8'h00,8'h00,0,0,4'b0000,0);
        vecs[19] = mk(0,0,0,8'h00,0,0,2,0, 8'h00,8'h00,0,0,4'b0000,0);

        drive(1,0,0,8'h00,0,0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state on every address of both ports.
        for (int a = 0; a < 4; a++) begin
            drive(0,0,0,8'h00,0,0,2'(a),2'(3 - a));
            #1;
            chk($sformatf("reset rd_data_a[%0d]", a), 32'(rd_data_a), 32'h0);
            chk($sformatf("reset rd_data_b[%0d]", 3 - a), 32'(rd_data_b), 32'h0);
        end
        chk("reset busy_vec", 32'(busy_vec), 32'h0);
        chk("reset rsv_err", 32'(rsv_err), 32'h0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re, vecs[i].ra, vecs[i].aa, vecs[i].ab);
            #1;
            chk($sformatf("v%0d rd_data_a", i), 32'(rd_data_a), 32'(vecs[i].eda));
            chk($sformatf("v%0d rd_data_b", i), 32'(rd_data_b), 32'(vecs[i].edb));
            chk($sformatf("v%0d busy_a", i), 32'(busy_a), 32'(vecs[i].eba));
            chk($sformatf("v%0d busy_b", i), 32'(busy_b), 32'(vecs[i].ebb));
            chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vecs[i].ebv));
            chk($sformatf("v%0d rsv_err", i), 32'(rsv_err), 32'(vecs[i].eerr));
            @(negedge clk);
        end

        // Forwarding corner: r3 loaded and reserved together, then written while read.
        drive(0,1,3,8'h10,1,3,3,0);
        #1;
`ifdef GP_REGFILE_BYPASS_EN
        chk("byp0 rd_data_a", 32'(rd_data_a), 32'h10);
        chk("byp0 busy_a", 32'(busy_a), 32'h1);
`else
        chk("byp0 rd_data_a", 32'(rd_data_a), 32'h00);
        chk("byp0 busy_a", 32'(busy_a), 32'h0);
`endif
        @(negedge clk);
        drive(0,1,3,8'h5A,0,0,3,3);
        #1;
        chk("byp1 busy_vec", 32'(busy_vec), 32'b1000);
`ifdef GP_REGFILE_BYPASS_EN
        chk("byp1 rd_data_a", 32'(rd_data_a), 32'h5A);
        chk("byp1 busy_a", 32'(busy_a), 32'h0);
        chk("byp1 busy_b", 32'(busy_b), 32'h0);
`else
        chk("byp1 rd_data_a", 32'(rd_data_a), 32'h10);
        chk("byp1 busy_a", 32'(busy_a), 32'h1);
        chk("byp1 busy_b", 32'(busy_b), 32'h1);
`endif
        @(negedge clk);
        drive(0,1,3,8'h6B,1,3,3,0);
        #1;
        chk("byp2 busy_vec", 32'(busy_vec), 32'b0000);
`ifdef GP_REGFILE_BYPASS_EN
        chk("byp2 rd_data_a", 32'(rd_data_a), 32'h6B);
        chk("byp2 busy_a", 32'(busy_a), 32'h1);
`else
        chk("byp2 rd_data_a", 32'(rd_data_a), 32'h5A);
        chk("byp2 busy_a", 32'(busy_a), 32'h0);
`endif
        @(negedge clk);
        drive(0,0,0,8'h00,0,0,3,0);
        #1;
        chk("byp3 rd_data_a", 32'(rd_data_a), 32'h6B);
        chk("byp3 busy_a", 32'(busy_a), 32'h1);
        chk("byp3 busy_vec", 32'(busy_vec), 32'b1000);
        chk("byp3 rsv_err", 32'(rsv_err), 32'h0);
        @(negedge clk);

        // ZERO_R0 instance: r0 and out-of-range address 3 are inert; reset mid-operation.
        drive(1,0,0,8'h00,0,0,0,0);
        @(negedge clk);
        drive(0,1,0,8'hFF,1,0,0,0);
        @(negedge clk);
        drive(0,0,0,8'h00,1,0,0,0);
        #1;
        chk("z r0 rd_data_a", 32'(z_rd_data_a), 32'h0);
        chk("z r0 busy_a", 32'(z_busy_a), 32'h0);
        chk("z r0 busy_vec", 32'(z_busy_vec), 32'h0);
        chk("z r0 rsv_err", 32'(z_rsv_err), 32'h0);
        @(negedge clk);
        drive(0,1,3,8'hAB,1,3,3,0);
        #1;
        chk("z r0 rsv twice rsv_err", 32'(z_rsv_err), 32'h0);
        @(negedge clk);
        drive(0,1,1,8'h77,1,1,3,3);
        #1;
        chk("z oor rd_data_a", 32'(z_rd_data_a), 32'h0);
        chk("z oor busy_a", 32'(z_busy_a), 32'h0);
        chk("z oor busy_vec", 32'(z_busy_vec), 32'h0);
        chk("z oor rsv_err", 32'(z_rsv_err), 32'h0);
        @(negedge clk);
        drive(0,0,0,8'h00,1,1,1,2);
        #1;
        chk("z r1 rd_data_a", 32'(z_rd_data_a), 32'h77);
        chk("z r1 busy_a", 32'(z_busy_a), 32'h1);
        chk("z r2 busy_b", 32'(z_busy_b), 32'h0);
        chk("z r1 busy_vec", 32'(z_busy_vec), 32'b010);
        @(negedge clk);
        drive(1,1,2,8'hCC,0,0,1,2);
        #1;
        chk("z collide rsv_err", 32'(z_rsv_err), 32'h1);
        chk("z collide busy_vec", 32'(z_busy_vec), 32'b010);
        @(negedge clk);
        drive(0,0,0,8'h00,0,0,1,2);
        #1;
        chk("z post-reset rd_data_a", 32'(z_rd_data_a), 32'h0);
        chk("z post-reset rd_data_b", 32'(z_rd_data_b), 32'h0);
        chk("z post-reset busy_a", 32'(z_busy_a), 32'h0);
        chk("z post-reset busy_vec", 32'(z_busy_vec), 32'h0);
        chk("z post-reset rsv_err", 32'(z_rsv_err), 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gp_regfile.md
Name: gp_regfile

Overview:
- Parametrised general-purpose register file for the 8-bit RISC CPU datapath.
- Provides one synchronous write port and two combinational read ports.
- Adds a per-register busy scoreboard: the issue stage reserves a destination register, and the writeback stage clears the reservation when it writes that register.
- Lets the control unit stall on read-after-write hazards instead of decoding one-hot load strobes.

Parameters:
DATA_W, 8, width of each register in bits
NUM_REGS, 4, number of registers (2..16)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS
ZERO_R0, 0, when 1 register 0 always reads 0, ignores writes and is never busy

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write strobe (writeback stage)
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data
rd_addr_a  input  ADDR_W  read port A index
rd_data_a  output  DATA_W  read port A data
rd_addr_b  input  ADDR_W  read port B index
rd_data_b  output  DATA_W  read port B data
rsv_en  input  1  reserve strobe (issue stage marks destination as pending)
rsv_addr  input  ADDR_W  register to reserve
busy_a  output  1  register at rd_addr_a is reserved
busy_b  output  1  register at rd_addr_b is reserved
busy_vec  output  NUM_REGS  registered busy flags, bit i = register i
rsv_err  output  1  registered one-cycle pulse: reservation of an already-busy register

Behaviour:
- Reset is synchronous and active-high. While reset is sampled high at a clk edge:
  - all registers become 0;
  - busy_vec becomes 0;
  - rsv_err becomes 0;
  - wr_en and rsv_en in that cycle are ignored.
- Reset asserted mid-operation discards pending reservations; there is no recovery of in-flight state.
- Write:
  - on an edge with wr_en=1 and a valid wr_addr, regs[wr_addr] <= wr_data.
  - Valid means wr_addr < NUM_REGS and not (ZERO_R0 and wr_addr==0).
  - Write latency is 1 cycle.
  - All registers are independently writable; there is no priority chain between registers.
- Read:
  - rd_data_x = regs[rd_addr_x], combinational.
  - An out-of-range address reads 0.
  - With ZERO_R0=1, address 0 reads 0.
  - Both ports may read the same address.
- Scoreboard, per register i, evaluated at each edge (after the reset check):
  - rsv_en=1 and rsv_addr==i: busy[i] <= 1.
  - Otherwise, wr_en=1 and wr_addr==i: busy[i] <= 0.
  - Otherwise busy[i] holds.
- Reserve and write to the same register in the same cycle: the data is written and busy stays or becomes 1, because the new producer wins.
- A write to a non-busy register is legal (direct load); busy stays 0.
- rsv_err:
  - rsv_err <= rsv_en & busy[rsv_addr] & valid(rsv_addr);
  - busy stays 1 in that case;
  - rsv_err is 0 on any cycle without such a collision.
- An invalid rsv_addr (out of range, or R0 with ZERO_R0) is ignored and does not raise rsv_err.
- busy_x = busy[rd_addr_x], combinational from the registered flags; it reads 0 for invalid addresses.
- There are no X outputs after reset; every output is defined for all address values.

Optional Feature:
Macro: GP_REGFILE_BYPASS_EN
- Defined:
  - write-to-read forwarding: when wr_en=1 and the write is valid with wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle;
  - busy_x is 0 in that cycle unless rsv_en=1 with rsv_addr==rd_addr_x in the same cycle.
  - Decode sees writeback results with zero-cycle delay.
- Not defined:
  - rd_data_x and busy_x reflect only registered state;
  - new data and the cleared busy flag are visible from the cycle after the write edge.

Test Plan:
- Reset then reads: assert reset 1 cycle → rd_data_a/b=0 for all addresses 0..3; busy_vec=4'b0000; rsv_err=0.
- Write/read: write 8'hA5 to r2, then 8'h3C to r3 → next cycle rd_addr_a=2 gives 8'hA5 and rd_addr_b=3 gives 8'h3C; r0 and r1 remain 0.
- Scoreboard: rsv_en on r1 → busy_vec=4'b0010 next cycle, busy_a=1 with rd_addr_a=1; write 8'h77 to r1 → busy_vec=0 and rd_data_a=8'h77 on the following cycle.
- Collision: rsv_en on r1 while r1 is busy → rsv_err=1 for exactly one cycle, busy_vec[1] stays 1. Simultaneous rsv r2 + write r2=8'h11 → r2=8'h11 and busy_vec[2]=1.
- Bypass (macro defined): r3 busy, write r3=8'h5A with rd_addr_a=3 → same cycle rd_data_a=8'h5A, busy_a=0. With the macro undefined, the same cycle shows the old value and busy_a=1.
- ZERO_R0=1 and reset mid-operation:
  - write r0=8'hFF → rd_data=0; rsv r0 → busy_vec[0]=0, rsv_err=0.
  - assert reset with r1 busy and r1=8'h77 → the next cycle shows all registers 0 and busy_vec=0.
